// File: rtl/round_key_store_pkg.sv
// Shared definitions for the round-key store: FSM encoding, default geometry and bank ids.
package round_key_store_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_ZERO   = 2'd2
  } state_e;

  localparam int KEY_W_DEF = 128;
  localparam int DEPTH_DEF = 33;
  localparam int BANKS_DEF = 2;

  localparam int BANK_DATA  = 0;
  localparam int BANK_TWEAK = 1;

endpackage

// File: rtl/round_key_store_bank_ram.sv
// One key bank: DEPTH x KEY_W storage, single write port, registered read port, no reset.
module round_key_store_bank_ram
  import round_key_store_pkg::*;
#(
  parameter int KEY_W  = KEY_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [KEY_W-1:0]  i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [KEY_W-1:0]  o_rd_data
);

  logic [KEY_W-1:0] r_mem [DEPTH];
  logic [KEY_W-1:0] r_rdData;

  // Write port; contents are deliberately left unreset so this maps onto a RAM macro
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read port holds its last value when no read is issued, which lets the stream stall
  always_ff @(posedge i_clk) begin
    if (i_rd_en) begin
      r_rdData <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rdData;

endmodule

// File: rtl/round_key_store.sv
// Multi-bank round-key store: bank writes, ordered streaming with valid/ready, zeroize sweep.
module round_key_store
  import round_key_store_pkg::*;
#(
  parameter  int KEY_W  = KEY_W_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  parameter  int BANKS  = BANKS_DEF,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_wr_en,
  input  logic [BANK_W-1:0] i_wr_bank,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [KEY_W-1:0]  i_wr_key,
  input  logic              i_start,
  input  logic [BANK_W-1:0] i_bank,
  input  logic              i_reverse,
  input  logic              i_zeroize,
  input  logic              i_key_ready,
  output logic              o_key_valid,
  output logic [KEY_W-1:0]  o_key,
  output logic [ADDR_W-1:0] o_key_idx,
  output logic              o_last,
  output logic              o_busy,
  output logic [BANKS-1:0]  o_bank_loaded,
  output logic              o_err,
  output logic              o_zero_done
);

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [BANK_W:0]   BANKS_EXT = (BANK_W + 1)'(BANKS);

  state_e r_state;
  state_e w_nextState;

  logic [BANK_W-1:0] r_bank;
  logic              r_rev;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_issuing;
  logic              r_s1Valid;
  logic [ADDR_W-1:0] r_s1Idx;
  logic              r_s1Last;
  logic              r_keyValid;
  logic [KEY_W-1:0]  r_key;
  logic [ADDR_W-1:0] r_keyIdx;
  logic              r_last;
  logic              r_err;
  logic              r_zeroDone;
  logic [BANKS-1:0]  r_loaded;
  logic [ADDR_W-1:0] r_zcnt;

  logic w_wrBankOk;
  logic w_wrAddrOk;
  logic w_wrConflict;
  logic w_wrAllowed;
  logic w_wrOk;
  logic w_wrErr;
  logic w_startBankOk;
  logic w_startLoaded;
  logic w_startReq;
  logic w_startOk;
  logic w_startErr;
  logic w_load;
  logic w_s1Adv;
  logic w_issue;
  logic w_ptrLast;
  logic w_lastAccept;
  logic w_zeroLast;

  logic [KEY_W-1:0] w_rdData [BANKS];
  logic [KEY_W-1:0] w_rdSel;

  // Write acceptance: a stream's own bank is frozen, everything is frozen during the sweep
  assign w_wrBankOk   = {1'b0, i_wr_bank} < BANKS_EXT;
  assign w_wrAddrOk   = {1'b0, i_wr_addr} < DEPTH_EXT;
  assign w_wrConflict = (r_state == ST_STREAM) && (i_wr_bank == r_bank);
  assign w_wrAllowed  = (r_state != ST_ZERO) && w_wrBankOk && w_wrAddrOk && !w_wrConflict;
  assign w_wrOk       = i_wr_en && !i_zeroize && w_wrAllowed;
  assign w_wrErr      = i_wr_en && !i_zeroize && !w_wrAllowed;

  // Start acceptance uses the registered loaded flags, so a same-cycle write cannot enable it
  assign w_startBankOk = {1'b0, i_bank} < BANKS_EXT;
  assign w_startLoaded = w_startBankOk && r_loaded[i_bank];
  assign w_startReq    = (r_state == ST_IDLE) && i_start && !i_zeroize;
  assign w_startOk     = w_startReq && w_startLoaded;
  assign w_startErr    = w_startReq && !w_startLoaded;

  // Two-stage pipe: RAM read register (stage 1) feeding the output register
  assign w_load       = !r_keyValid || i_key_ready;
  assign w_s1Adv      = r_s1Valid && w_load;
  assign w_issue      = (r_state == ST_STREAM) && r_issuing && (!r_s1Valid || w_s1Adv);
  assign w_ptrLast    = r_rev ? (r_ptr == '0) : (r_ptr == LAST_IDX);
  assign w_lastAccept = r_keyValid && r_last && i_key_ready;
  assign w_zeroLast   = (r_state == ST_ZERO) && (r_zcnt == LAST_IDX);

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic              w_bankWrEn;
    logic [ADDR_W-1:0] w_bankWrAddr;
    logic [KEY_W-1:0]  w_bankWrData;
    logic              w_bankRdEn;

    assign w_bankWrEn   = (r_state == ST_ZERO) || (w_wrOk && (i_wr_bank == BANK_W'(b)));
    assign w_bankWrAddr = (r_state == ST_ZERO) ? r_zcnt : i_wr_addr;
    assign w_bankWrData = (r_state == ST_ZERO) ? '0 : i_wr_key;
    assign w_bankRdEn   = w_issue && (r_bank == BANK_W'(b));

    round_key_store_bank_ram #(
      .KEY_W  (KEY_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_ram (
      .i_clk     (i_clk),
      .i_wr_en   (w_bankWrEn),
      .i_wr_addr (w_bankWrAddr),
      .i_wr_data (w_bankWrData),
      .i_rd_en   (w_bankRdEn),
      .i_rd_addr (r_ptr),
      .o_rd_data (w_rdData[b])
    );
  end

  assign w_rdSel = w_rdData[r_bank];

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // FSM next state; zeroize overrides every other transition
  always_comb begin
    w_nextState = r_state;
    if (i_zeroize) begin
      w_nextState = ST_ZERO;
    end else begin
      case (r_state)
        ST_IDLE:   if (w_startOk)    w_nextState = ST_STREAM;
        ST_STREAM: if (w_lastAccept) w_nextState = ST_IDLE;
        ST_ZERO:   if (w_zeroLast)   w_nextState = ST_IDLE;
        default:                     w_nextState = ST_IDLE;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    o_busy = (r_state != ST_IDLE);
  end

  // Read pointer, stage-1 tag and output register; key is zero whenever the beat is not valid
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_bank     <= '0;
      r_rev      <= 1'b0;
      r_ptr      <= '0;
      r_issuing  <= 1'b0;
      r_s1Valid  <= 1'b0;
      r_s1Idx    <= '0;
      r_s1Last   <= 1'b0;
      r_keyValid <= 1'b0;
      r_key      <= '0;
      r_keyIdx   <= '0;
      r_last     <= 1'b0;
    end else if (i_zeroize) begin
      r_issuing  <= 1'b0;
      r_s1Valid  <= 1'b0;
      r_keyValid <= 1'b0;
      r_key      <= '0;
      r_keyIdx   <= '0;
      r_last     <= 1'b0;
    end else if (w_startOk) begin
      r_bank    <= i_bank;
      r_rev     <= i_reverse;
      r_ptr     <= i_reverse ? LAST_IDX : '0;
      r_issuing <= 1'b1;
      r_s1Valid <= 1'b0;
    end else begin
      if (w_issue) begin
        r_s1Valid <= 1'b1;
        r_s1Idx   <= r_ptr;
        r_s1Last  <= w_ptrLast;
        if (w_ptrLast) begin
          r_issuing <= 1'b0;
        end else begin
          r_ptr <= r_rev ? (r_ptr - 1'b1) : (r_ptr + 1'b1);
        end
      end else if (w_s1Adv) begin
        r_s1Valid <= 1'b0;
      end
      if (w_load) begin
        r_keyValid <= r_s1Valid;
        r_key      <= r_s1Valid ? w_rdSel : '0;
        r_keyIdx   <= r_s1Valid ? r_s1Idx : '0;
        r_last     <= r_s1Valid && r_s1Last;
      end
    end
  end

  // Status pulses, loaded flags and the zeroize sweep counter
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_err      <= 1'b0;
      r_zeroDone <= 1'b0;
      r_zcnt     <= '0;
      r_loaded   <= '0;
    end else begin
      r_err      <= w_wrErr || w_startErr;
      r_zeroDone <= w_zeroLast && !i_zeroize;
      if (i_zeroize) begin
        r_zcnt <= '0;
      end else if ((r_state == ST_ZERO) && !w_zeroLast) begin
        r_zcnt <= r_zcnt + 1'b1;
      end else begin
        r_zcnt <= '0;
      end
      if (i_zeroize) begin
        r_loaded <= '0;
      end else if (w_wrOk && (i_wr_addr == LAST_IDX)) begin
        r_loaded[i_wr_bank] <= 1'b1;
      end
    end
  end

  assign o_key_valid   = r_keyValid;
  assign o_key         = r_key;
  assign o_key_idx     = r_keyIdx;
  assign o_last        = r_last;
  assign o_bank_loaded = r_loaded;
  assign o_err         = r_err;
  assign o_zero_done   = r_zeroDone;

endmodule
